// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and APB-side signals for apb_req_arbiter.
// master: the arbiter view (drives grants, responses and APB request lines).
// slave:  the environment view (drives requests and APB slave responses).
`timescale 1ns/1ps
interface apb_req_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*AWIDTH-1:0] req_addr;
    logic [NREQ*DWIDTH-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [DWIDTH-1:0]      resp_rdata;
    logic                   resp_err;
    logic                   p_sel;
    logic                   p_en;
    logic                   p_write;
    logic [AWIDTH-1:0]      addr;
    logic [DWIDTH-1:0]      wdata;
    logic [DWIDTH-1:0]      rdata;
    logic                   p_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rdata, p_ready,
        output req_ready, resp_valid, resp_rdata, resp_err,
               p_sel, p_en, p_write, addr, wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rdata, p_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               p_sel, p_en, p_write, addr, wdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB slave between NREQ requesters.
// Round-robin arbitration, APB SETUP/ACCESS sequencing, completion routed
// back to the granted requester. All outputs are registered.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase timeout with resp_err).
`timescale 1ns/1ps
module apb_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    apb_req_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_r;
    logic [PW-1:0]     rr_ptr_r;
    logic [PW-1:0]     owner_r;
    logic [NREQ-1:0]   req_ready_r;
    logic [NREQ-1:0]   resp_valid_r;
    logic [DWIDTH-1:0] resp_rdata_r;
    logic              p_sel_r;
    logic              p_en_r;
    logic              p_write_r;
    logic [AWIDTH-1:0] addr_r;
    logic [DWIDTH-1:0] wdata_r;

    logic              grant_any_s;
    logic [PW-1:0]     grant_idx_s;
    logic [PW-1:0]     rr_next_s;
    logic              sel_write_s;
    logic [AWIDTH-1:0] sel_addr_s;
    logic [DWIDTH-1:0] sel_wdata_s;
    logic              done_s;
    logic              abort_s;
    logic              launch_s;

    // Requester index k positions after base, wrapping at NREQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return PW'((s >= NREQ) ? (s - NREQ) : s);
    endfunction

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_r;
    logic          resp_err_r;
`else
    logic [31:0]   unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
`endif

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = rr_ptr_r;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any_s && bus.req_valid[rr_idx(rr_ptr_r, k)]) begin
                grant_any_s = 1'b1;
                grant_idx_s = rr_idx(rr_ptr_r, k);
            end else begin
            end
        end
    end

    // Winner's request fields and the pointer value that follows it.
    always_comb begin
        rr_next_s   = (grant_idx_s == PW'(NREQ - 1)) ? '0 : (grant_idx_s + 1'b1);
        sel_write_s = bus.req_write[grant_idx_s];
        sel_addr_s  = bus.req_addr[int'(grant_idx_s) * AWIDTH +: AWIDTH];
        sel_wdata_s = bus.req_wdata[int'(grant_idx_s) * DWIDTH +: DWIDTH];
    end

    // End of ACCESS: slave ready (always wins) or, optionally, timeout abort.
    always_comb begin
        done_s  = 1'b0;
        abort_s = 1'b0;
        if (state_r == ST_ACCESS) begin
            if (bus.p_ready) begin
                done_s = 1'b1;
            end
`ifdef APB_TIMEOUT_EN
            else if (tcnt_r == TW'(TIMEOUT - 1)) begin
                done_s  = 1'b1;
                abort_s = 1'b1;
            end
`endif
            else begin
            end
        end else begin
        end
        launch_s = grant_any_s && ((state_r == ST_IDLE) || done_s);
    end

    // Main FSM: grant, APB phase sequencing and response generation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            owner_r      <= '0;
            req_ready_r  <= '0;
            resp_valid_r <= '0;
            resp_rdata_r <= '0;
            p_sel_r      <= 1'b0;
            p_en_r       <= 1'b0;
            p_write_r    <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
        end else begin
            req_ready_r  <= '0;
            resp_valid_r <= '0;
            if (done_s) begin
                resp_valid_r[owner_r] <= 1'b1;
                if (abort_s) begin
                    resp_rdata_r <= '0;
                end else if (!p_write_r) begin
                    resp_rdata_r <= bus.rdata;
                end else begin
                    resp_rdata_r <= resp_rdata_r;
                end
            end
            if (launch_s) begin
                // Back-to-back launch from ACCESS keeps p_sel high.
                state_r                  <= ST_SETUP;
                p_sel_r                  <= 1'b1;
                p_en_r                   <= 1'b0;
                p_write_r                <= sel_write_s;
                addr_r                   <= sel_addr_s;
                wdata_r                  <= sel_wdata_s;
                req_ready_r[grant_idx_s] <= 1'b1;
                owner_r                  <= grant_idx_s;
                rr_ptr_r                 <= rr_next_s;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        p_sel_r <= 1'b0;
                        p_en_r  <= 1'b0;
                    end
                    ST_SETUP: begin
                        p_en_r  <= 1'b1;
                        state_r <= ST_ACCESS;
                    end
                    ST_ACCESS: begin
                        if (done_s) begin
                            state_r <= ST_IDLE;
                            p_sel_r <= 1'b0;
                            p_en_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        p_sel_r <= 1'b0;
                        p_en_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS wait counter: cleared in SETUP (the only way into ACCESS).
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt_r <= '0;
        end else if (state_r == ST_SETUP) begin
            tcnt_r <= '0;
        end else if ((state_r == ST_ACCESS) && !done_s) begin
            tcnt_r <= tcnt_r + 1'b1;
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // Error flag, updated on every completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_err_r <= 1'b0;
        end else if (done_s) begin
            resp_err_r <= abort_s;
        end else begin
            resp_err_r <= resp_err_r;
        end
    end

    assign bus.resp_err = resp_err_r;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.p_sel      = p_sel_r;
    assign bus.p_en       = p_en_r;
    assign bus.p_write    = p_write_r;
    assign bus.addr       = addr_r;
    assign bus.wdata      = wdata_r;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: per-requester drivers push expected
// responses at grant time; one monitor checks grants, responses and APB
// phase stability. Timeout scenario runs when APB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) bus ();

    apb_req_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] er;
        bit          cr;
        bit          err;
        int          lat;
        bit          cg;
    } cmd_t;

    typedef struct {
        int          owner;
        logic [31:0] er;
        bit          cr;
        bit          err;
        int          lat;
        int          gcyc;
    } sb_t;

    cmd_t cmdq[NREQ][$];
    sb_t  sb[$];
    int   exp_grant[$];
    int   tests    = 0;
    int   fails    = 0;
    int   pending  = 0;
    int   cyc      = 0;
    int   slv_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // APB RAM slave with programmable wait states
    logic [31:0] mem [0:255];
    logic        p_ready_r = 1'b0;
    int          wcnt      = 0;
    assign bus.p_ready = p_ready_r;
    assign bus.rdata   = mem[bus.addr];

    always @(posedge clk) begin
        if (bus.p_sel && bus.p_en && !p_ready_r) begin
            if (wcnt >= slv_wait) begin
                p_ready_r <= 1'b1;
                wcnt      <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            p_ready_r <= 1'b0;
            wcnt      <= 0;
        end
        if (bus.p_sel && bus.p_en && p_ready_r && bus.p_write) mem[bus.addr] <= bus.wdata;
    end

    // Requester drivers: hold a request until req_ready, then take the next
    for (genvar g = 0; g < NREQ; g++) begin : g_drv
        logic        v = 1'b0;
        logic        w = 1'b0;
        logic [7:0]  a = 8'h00;
        logic [31:0] d = 32'h0;
        assign bus.req_valid[g]          = v;
        assign bus.req_write[g]          = w;
        assign bus.req_addr[g*AW +: AW]  = a;
        assign bus.req_wdata[g*DW +: DW] = d;

        initial begin
            cmd_t c;
            sb_t  e;
            int   n;
            int   rc;
            forever begin
                if (cmdq[g].size() > 0) begin
                    c  = cmdq[g].pop_front();
                    w  = c.w;
                    a  = c.a;
                    d  = c.d;
                    v  = 1'b1;
                    rc = cyc;
                    n  = 0;
                    do begin
                        @(posedge clk); #1;
                        n++;
                    end while (!bus.req_ready[g] && n < 500);
                    if (!bus.req_ready[g]) begin
                        tests++;
                        fails++;
                        $display("FAIL grant_wait: requester %0d got no req_ready, required one within 500 cycles", g);
                        v = 1'b0;
                    end else begin
                        e.owner = g;
                        e.er    = c.er;
                        e.cr    = c.cr;
                        e.err   = c.err;
                        e.lat   = c.lat;
                        e.gcyc  = cyc;
                        sb.push_back(e);
                        if (c.cg) check("grant_latency", 64'(cyc - rc), 64'd1);
                        v = 1'b0;
                    end
                end else begin
                    v = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
    end

    // Monitor: grant order, response scoreboard, ACCESS-phase stability
    initial begin
        sb_t         e;
        int          gi;
        logic [40:0] held;
        held = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: req_ready=%b, required none", bus.req_ready);
                end else begin
                    gi = exp_grant.pop_front();
                    check("grant_order", 64'(bus.req_ready), 64'd1 << gi);
                end
            end
            if (bus.resp_valid != '0) begin
                check("resp_onehot", 64'($countones(bus.resp_valid)), 64'd1);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: resp_valid=%b, required none", bus.resp_valid);
                end else begin
                    e = sb.pop_front();
                    pending--;
                    check("resp_owner", 64'(bus.resp_valid), 64'd1 << e.owner);
                    if (e.cr) check("resp_rdata", 64'(bus.resp_rdata), 64'(e.er));
                    check("resp_err", 64'(bus.resp_err), 64'(e.err));
                    if (e.lat >= 0) check("resp_latency", 64'(cyc - e.gcyc), 64'(e.lat));
                end
            end
            if (bus.p_sel && !bus.p_en) begin
                held = {bus.p_write, bus.addr, bus.wdata};
            end else if (bus.p_sel && bus.p_en) begin
                check("access_stable", 64'({bus.p_write, bus.addr, bus.wdata}), 64'(held));
            end
        end
    end

    task automatic push(input int r, input bit w, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] er, input bit cr, input bit err, input int lat, input bit cg);
        cmd_t c;
        c.w = w; c.a = a; c.d = d; c.er = er; c.cr = cr; c.err = err; c.lat = lat; c.cg = cg;
        cmdq[r].push_back(c);
        pending++;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((pending != 0 || exp_grant.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 64'(pending), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ctrl"}, 64'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.p_sel,
                                   bus.p_en, bus.p_write, bus.addr}), 64'd0);
        check({nm, "_rdata"}, 64'(bus.resp_rdata), 64'd0);
        check({nm, "_wdata"}, 64'(bus.wdata), 64'd0);
    endtask

    initial begin
        int          n;
        logic [11:0] sel_v;
        logic [11:0] en_v;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single write then read back through requester 0
        @(negedge clk);
        exp_grant = '{0, 0};
        push(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0, 3, 1'b1);
        push(0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b0);
        drain("drain_single");

        // Back-to-back writes from requester 1: p_sel held, p_en 0,1,1
        @(negedge clk);
        exp_grant = '{1, 1, 1, 1};
        for (int i = 0; i < 4; i++)
            push(1, 1'b1, 8'(i), 32'hC0DE0000 + 32'(i), 32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.p_sel && n < 50);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            sel_v[i] = bus.p_sel;
            en_v[i]  = bus.p_en;
        end
        check("b2b_psel", 64'(sel_v), 64'hFFF);
        check("b2b_pen", 64'(en_v), 64'hDB6);
        @(posedge clk); #1;
        check("b2b_psel_drop", 64'(bus.p_sel), 64'd0);
        drain("drain_b2b");

        // Contention: both requesters hold three reads each
        @(negedge clk);
        exp_grant = '{0, 1, 0, 1, 0, 1};
        push(0, 1'b0, 8'h00, 32'h0, 32'hC0DE0000, 1'b1, 1'b0, 3, 1'b0);
        push(0, 1'b0, 8'h01, 32'h0, 32'hC0DE0001, 1'b1, 1'b0, 3, 1'b0);
        push(0, 1'b0, 8'h02, 32'h0, 32'hC0DE0002, 1'b1, 1'b0, 3, 1'b0);
        push(1, 1'b0, 8'h03, 32'h0, 32'hC0DE0003, 1'b1, 1'b0, 3, 1'b0);
        push(1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b0);
        push(1, 1'b0, 8'h00, 32'h0, 32'hC0DE0000, 1'b1, 1'b0, 3, 1'b0);
        drain("drain_contention");

        // Five wait states per transfer
        @(negedge clk);
        slv_wait  = 5;
        exp_grant = '{0, 0};
        push(0, 1'b1, 8'h20, 32'hA5A50001, 32'hC0DE0000, 1'b1, 1'b0, 8, 1'b0);
        push(0, 1'b0, 8'h20, 32'h0,        32'hA5A50001, 1'b1, 1'b0, 8, 1'b0);
        drain("drain_wait");
        slv_wait = 0;

        // Reset while in ACCESS: transfer abandoned, no response
        @(negedge clk);
        slv_wait  = 20;
        exp_grant = '{0};
        push(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.p_en && n < 50);
        check("mid_reached_access", 64'(bus.p_en), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        pending--;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst      = 1'b1;
        slv_wait = 0;
        repeat (5) @(posedge clk);
        // rr_ptr back at 0: requester 0 wins first
        @(negedge clk);
        exp_grant = '{0, 1};
        push(0, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b0);
        push(1, 1'b0, 8'h20, 32'h0, 32'hA5A50001, 1'b1, 1'b0, 3, 1'b0);
        drain("drain_after_reset");

`ifdef APB_TIMEOUT_EN
        // Stuck slave: abort after TIMEOUT ACCESS cycles, pending req1 follows
        @(negedge clk);
        slv_wait  = 1000;
        exp_grant = '{0, 1};
        push(0, 1'b0, 8'h10, 32'h0, 32'h0,        1'b1, 1'b1, TO + 1, 1'b0);
        push(1, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 3,      1'b0);
        n = 0;
        while (pending != 1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        slv_wait = 0;
        drain("drain_timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
